uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of uart_top. It captures each single-cycle rx_valid/rx_data/rx_error pulse from the UART receiver into a first-word-fall-through FIFO. Bytes are presented to the host logic over a valid/ready interface. It also reports fill level, a threshold flag, and sticky overrun and error statistics, because the UART receiver has no backpressure.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/sat_cnt8.sv | 29 ++
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO slice.
package uart_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int THRESH_DEF = 12;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver into the FIFO and out to the host (valid/ready).
interface uart_rx_fifo_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rx_data, rx_valid, rx_error, out_ready,
    input  out_data, out_err, out_valid
  );

  modport slave (
    input  rx_data, rx_valid, rx_error, out_ready,
    output out_data, out_err, out_valid
  );

endinterface

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter; an increment in the same cycle as a clear leaves it at 1.
module sat_cnt8
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'h00;
    end else if (inc) begin
      if (clr)
        cnt_reg <= 8'h01;
      else if (cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + 8'h01;
    end else if (clr) begin
      cnt_reg <= 8'h00;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with fill status
// and sticky overrun/error statistics (the receiver cannot be stalled).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int THRESH   = THRESH_DEF,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_rx_fifo_if.slave            bus,
  input  logic                     flush,
  input  logic                     ovr_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     thresh,
  output logic                     overrun,
  output logic [7:0]               ovr_cnt,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fifo_entry_t mem [DEPTH];
  fifo_entry_t head;

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] level_reg, level_next;
  logic        empty_reg, empty_next;
  logic        full_reg, full_next;
  logic        thresh_reg, thresh_next;
  logic        overrun_reg;

  logic push_req, push_ok, pop, ovr_evt, err_evt;

  always_comb begin
    push_req = bus.rx_valid & ~(DROP_ERR & bus.rx_error);
    pop      = ~empty_reg & bus.out_ready;
    // A pop frees the slot a same-cycle push needs, so full only blocks a lone push.
    push_ok  = push_req & (~full_reg | pop);
    ovr_evt  = push_req & full_reg & ~pop & ~flush;
    err_evt  = bus.rx_valid & bus.rx_error;

    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_next = rd_ptr_reg + PW'(1);
    end

    level_next  = wr_ptr_next - rd_ptr_next;
    empty_next  = (wr_ptr_next == rd_ptr_next);
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    thresh_next = (level_next >= PW'(THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      thresh_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      level_reg   <= level_next;
      empty_reg   <= empty_next;
      full_reg    <= full_next;
      thresh_reg  <= thresh_next;
      if (ovr_evt)
        overrun_reg <= 1'b1;
      else if (ovr_clr)
        overrun_reg <= 1'b0;
    end
  end

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr_reg[AW-1:0]] <= '{err: bus.rx_error, data: bus.rx_data};
  end

  assign head = mem[rd_ptr_reg[AW-1:0]];

  // Head is masked while empty so stale or uninitialised entries never leak out.
  assign bus.out_data  = empty_reg ? 8'h00 : head.data;
  assign bus.out_err   = empty_reg ? 1'b0  : head.err;
  assign bus.out_valid = ~empty_reg;

  logic [1:0] cnt_inc;
  logic [7:0] cnt_val [2];

  assign cnt_inc = {err_evt, ovr_evt};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_cnt8 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc[gi]),
        .clr   (ovr_clr),
        .cnt   (cnt_val[gi])
      );
    end
  endgenerate

  assign level   = level_reg;
  assign empty   = empty_reg;
  assign full    = full_reg;
  assign thresh  = thresh_reg;
  assign overrun = overrun_reg;
  assign ovr_cnt = cnt_val[0];
  assign err_cnt = cnt_val[1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: a stored-error FIFO and an error-dropping FIFO driven in lockstep.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ovr_clr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if bus0 ();
  uart_rx_fifo_if bus1 ();

  logic [4:0] level0, level1;
  logic       empty0, full0, thresh0, overrun0;
  logic       empty1, full1, thresh1, overrun1;
  logic [7:0] ovr_cnt0, err_cnt0, ovr_cnt1, err_cnt1;

  uart_rx_fifo #(.DEPTH(16), .THRESH(12), .DROP_ERR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .flush(flush), .ovr_clr(ovr_clr),
    .level(level0), .empty(empty0), .full(full0), .thresh(thresh0),
    .overrun(overrun0), .ovr_cnt(ovr_cnt0), .err_cnt(err_cnt0)
  );

  uart_rx_fifo #(.DEPTH(16), .THRESH(12), .DROP_ERR(1'b1)) dut_drop (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .flush(flush), .ovr_clr(ovr_clr),
    .level(level1), .empty(empty1), .full(full1), .thresh(thresh1),
    .overrun(overrun1), .ovr_cnt(ovr_cnt1), .err_cnt(err_cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus into both FIFOs, then return inputs to idle.
  task automatic apply(input logic v, input logic [7:0] d, input logic e,
                       input logic rdy, input logic fl, input logic clr);
    bus0.rx_valid = v;  bus0.rx_data = d;  bus0.rx_error = e;  bus0.out_ready = rdy;
    bus1.rx_valid = v;  bus1.rx_data = d;  bus1.rx_error = e;  bus1.out_ready = rdy;
    flush = fl;
    ovr_clr = clr;
    @(posedge clk);
    #1;
    bus0.rx_valid = 1'b0; bus0.rx_data = 8'h00; bus0.rx_error = 1'b0; bus0.out_ready = 1'b0;
    bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00; bus1.rx_error = 1'b0; bus1.out_ready = 1'b0;
    flush = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},   int'(level0),        0);
    chk({tag, "_empty"},   int'(empty0),        1);
    chk({tag, "_valid"},   int'(bus0.out_valid), 0);
    chk({tag, "_full"},    int'(full0),         0);
    chk({tag, "_thresh"},  int'(thresh0),       0);
    chk({tag, "_overrun"}, int'(overrun0),      0);
    chk({tag, "_ovr_cnt"}, int'(ovr_cnt0),      0);
    chk({tag, "_err_cnt"}, int'(err_cnt0),      0);
    chk({tag, "_data"},    int'(bus0.out_data), 0);
    chk({tag, "_err"},     int'(bus0.out_err),  0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       rdy;
    logic       fl;
    logic       clr;
    int         x_valid;
    int         x_data;
    int         x_err;
    int         x_level;
    int         x_err_cnt;
    int         x_dlevel;
    int         x_derr_cnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    //          v     d      e     rdy   fl    clr   val dat    err lvl ecnt dlvl decnt
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 'h00, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 'hA5, 0, 1, 0, 1, 0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h00, 0, 0, 0, 0, 0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1, 'h3C, 1, 1, 1, 0, 1};
    tbl[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1, 'h11, 0, 1, 1, 1, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h00, 0, 0, 1, 0, 1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 'h00, 0, 0, 0, 0, 0};

    bus0.rx_valid = 1'b0; bus0.rx_data = 8'h00; bus0.rx_error = 1'b0; bus0.out_ready = 1'b0;
    bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00; bus1.rx_error = 1'b0; bus1.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_state("reset");

    // Single push/pop, error tagging, simultaneous push/pop, error-counter clear
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
      chk($sformatf("row%0d_valid", i),    int'(bus0.out_valid), tbl[i].x_valid);
      chk($sformatf("row%0d_data", i),     int'(bus0.out_data),  tbl[i].x_data);
      chk($sformatf("row%0d_err", i),      int'(bus0.out_err),   tbl[i].x_err);
      chk($sformatf("row%0d_level", i),    int'(level0),         tbl[i].x_level);
      chk($sformatf("row%0d_empty", i),    int'(empty0),         int'(tbl[i].x_level == 0));
      chk($sformatf("row%0d_err_cnt", i),  int'(err_cnt0),       tbl[i].x_err_cnt);
      chk($sformatf("row%0d_dlevel", i),   int'(level1),         tbl[i].x_dlevel);
      chk($sformatf("row%0d_derr_cnt", i), int'(err_cnt1),       tbl[i].x_derr_cnt);
      $display("row %0d: v=%0b d=%02h e=%0b rdy=%0b -> valid=%0b data=%02h level=%0d err_cnt=%0d",
               i, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rdy,
               bus0.out_valid, bus0.out_data, level0, err_cnt0);
    end

    // Fill to full, watching thresh and full edges
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d_level", i),  int'(level0),  i + 1);
      chk($sformatf("fill%0d_thresh", i), int'(thresh0), int'(i + 1 >= 12));
      chk($sformatf("fill%0d_full", i),   int'(full0),   int'(i + 1 == 16));
    end
    $display("fill: level=%0d full=%0b thresh=%0b", level0, full0, thresh0);
    chk("fill_head", int'(bus0.out_data), 'h00);

    apply(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_overrun", int'(overrun0), 1);
    chk("ovr_cnt",     int'(ovr_cnt0), 1);
    chk("ovr_level",   int'(level0),   16);
    $display("overrun push 0x99: overrun=%0b ovr_cnt=%0d", overrun0, ovr_cnt0);

    // Push and pop together while full: accepted, no overrun
    apply(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_level",   int'(level0),   16);
    chk("fullpp_full",    int'(full0),    1);
    chk("fullpp_ovr_cnt", int'(ovr_cnt0), 1);
    $display("full push+pop 0x77: level=%0d ovr_cnt=%0d", level0, ovr_cnt0);

    for (int k = 0; k < 16; k++) begin
      int exp_b;
      exp_b = (k < 15) ? k + 1 : 'h77;
      chk($sformatf("drain%0d_data", k),  int'(bus0.out_data),  exp_b);
      chk($sformatf("drain%0d_valid", k), int'(bus0.out_valid), 1);
      $display("drain %0d: data=%02h", k, bus0.out_data);
      apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", int'(empty0), 1);
    chk("drain_level", int'(level0), 0);

    // Flush beats a same-cycle push; statistics untouched
    for (int i = 0; i < 5; i++) apply(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("preflush_level", int'(level0), 5);
    apply(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_level",   int'(level0),         0);
    chk("flush_empty",   int'(empty0),         1);
    chk("flush_valid",   int'(bus0.out_valid), 0);
    chk("flush_overrun", int'(overrun0),       1);
    chk("flush_ovr_cnt", int'(ovr_cnt0),       1);
    $display("flush with push 0x55: level=%0d overrun=%0b", level0, overrun0);
    apply(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("postflush_data",  int'(bus0.out_data), 'hAB);
    chk("postflush_level", int'(level0),        1);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun counter saturation and clear-vs-event priority
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_overrun", int'(overrun0), 0);
    chk("clr_ovr_cnt", int'(ovr_cnt0), 0);
    for (int i = 0; i < 16; i++) apply(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) apply(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_ovr_cnt", int'(ovr_cnt0),       255);
    chk("sat_overrun", int'(overrun0),       1);
    chk("sat_level",   int'(level0),         16);
    chk("sat_head",    int'(bus0.out_data),  'h40);
    $display("300 overruns: ovr_cnt=%0d head=%02h", ovr_cnt0, bus0.out_data);
    apply(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clrset_overrun", int'(overrun0), 1);
    chk("clrset_ovr_cnt", int'(ovr_cnt0), 1);
    $display("ovr_clr with overrun: overrun=%0b ovr_cnt=%0d", overrun0, ovr_cnt0);

    // Asynchronous reset mid-fill, checked before any clock edge
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("premrst_level", int'(level0), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    $display("async reset mid-fill: level=%0d empty=%0b", level0, empty0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", int'(level0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
